ssd_scan_arbiter: RTL and testbench

SSD_SCAN_ARBITER -- requirements
Module: ssd_scan_arbiter

---
 rtl/ssd_scan_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ssd_scan_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_arbiter.sv
// Two-requester round-robin arbiter for a multiplexed two-digit seven-segment display.
// Optional: define SSD_LEADING_ZERO_BLANK_EN to blank a zero upper digit.
module ssd_scan_arbiter #(
    parameter int SCAN_DIV   = 2000000,
    parameter int HOLD_SCANS = 50
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [1:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] grant,
    output logic       sel,
    output logic [6:0] seg
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int HW = (HOLD_SCANS > 1) ? $clog2(HOLD_SCANS) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_SCANS - 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        HANDOFF
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pre_cnt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          owner, owner_nxt;   // current owner in OWN, otherwise last granted
    logic          tick;
    logic [1:0]    grant_nxt;
    logic [7:0]    owner_data;
    logic [3:0]    nib;
    logic [6:0]    seg_p0;

    function automatic logic pick(input logic [1:0] r, input logic last);
        return (r == 2'b11) ? ~last : r[1];
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h73;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pre_cnt <= '0;
            sel     <= 1'b0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                sel <= ~sel;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            owner    <= 1'b1;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = OWN;
                    owner_nxt = pick(req, owner);
                    hold_nxt  = '0;
                end
            end
            OWN: begin
                // Losing the request wins over hold expiry in the same cycle
                if (!req[owner]) begin
                    state_nxt = HANDOFF;
                end else if (tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nxt = '0;
                        if (req[~owner]) begin
                            state_nxt = HANDOFF;
                        end
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
            end
            HANDOFF: begin
                if (tick) begin
                    if (|req) begin
                        state_nxt = OWN;
                        owner_nxt = pick(req, owner);
                        hold_nxt  = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        grant_nxt = (state_nxt == OWN) ? (owner_nxt ? 2'b10 : 2'b01) : 2'b00;
    end

    // Segment decode from the current state/sel/data, registered one clock later
    always_comb begin
        owner_data = owner ? data1 : data0;
        nib        = sel ? owner_data[7:4] : owner_data[3:0];
        seg_p0     = 7'h00;
        if (state == OWN) begin
`ifdef SSD_LEADING_ZERO_BLANK_EN
            if (!(sel && (nib == 4'h0))) begin
                seg_p0 = hex7(nib);
            end
`else
            seg_p0 = hex7(nib);
`endif
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            grant <= 2'b00;
            seg   <= 7'h00;
        end else begin
            grant <= grant_nxt;
            seg   <= seg_p0;
        end
    end

endmodule

// File: tb/tb_ssd_scan_arbiter.sv
// Bench for ssd_scan_arbiter: directed scenarios, cycle-level reference model, literal pins.
`timescale 1ns/1ps
module tb_ssd_scan_arbiter;

    localparam int SCAN_DIV   = 4;
    localparam int HOLD_SCANS = 3;

    logic       clk   = 1'b0;
    logic       nrst  = 1'b1;
    logic [1:0] req   = 2'b00;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic [1:0] grant;
    logic       sel;
    logic [6:0] seg;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0=idle, 1=own, 2=handoff; m_last is the owner while in own
    int         m_mode, m_last, m_held, m_cnt;
    bit         m_sel;
    logic [6:0] m_seg;
    logic [1:0] m_grant;

    always #5 clk = ~clk;

    ssd_scan_arbiter #(.SCAN_DIV(SCAN_DIV), .HOLD_SCANS(HOLD_SCANS)) dut (
        .clk  (clk),
        .nrst (nrst),
        .req  (req),
        .data0(data0),
        .data1(data1),
        .grant(grant),
        .sel  (sel),
        .seg  (seg)
    );

    function automatic logic [6:0] hex_of(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
              7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        return t[n];
    endfunction

    function automatic logic [6:0] shown(input int mode, input int own, input bit s);
        logic [7:0] d;
        logic [3:0] n;
        if (mode != 1) return 7'h00;
        d = (own == 1) ? data1 : data0;
        n = s ? d[7:4] : d[3:0];
`ifdef SSD_LEADING_ZERO_BLANK_EN
        if (s && n == 4'h0) return 7'h00;
`endif
        return hex_of(n);
    endfunction

    function automatic int winner(input logic [1:0] r, input int last);
        if (r == 2'b11) return 1 - last;
        return r[0] ? 0 : 1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_last = 1; m_held = 0; m_cnt = 0;
        m_sel = 1'b0; m_seg = 7'h00; m_grant = 2'b00;
    endtask

    task automatic model_step();
        bit tk;
        if (!nrst) return;
        tk = (m_cnt == SCAN_DIV - 1);
        m_seg = shown(m_mode, m_last, m_sel);
        if (m_mode == 0) begin
            if (req != 2'b00) begin m_last = winner(req, m_last); m_mode = 1; m_held = 0; end
        end else if (m_mode == 1) begin
            if (!req[m_last]) m_mode = 2;
            else if (tk) begin
                m_held++;
                if (m_held == HOLD_SCANS) begin
                    m_held = 0;
                    if (req[1 - m_last]) m_mode = 2;
                end
            end
        end else if (tk) begin
            if (req != 2'b00) begin m_last = winner(req, m_last); m_mode = 1; m_held = 0; end
            else m_mode = 0;
        end
        if (tk) m_sel = ~m_sel;
        m_cnt = tk ? 0 : m_cnt + 1;
        m_grant = (m_mode == 1) ? ((m_last == 1) ? 2'b10 : 2'b01) : 2'b00;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model at the edge, compare all outputs at the falling edge
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_grant", 8'(grant), 8'(m_grant));
        check("model_sel", 8'(sel), 8'(m_sel));
        check("model_seg", 8'(seg), 8'(m_seg));
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        model_reset();
        cyc();
        cyc();
        nrst = 1'b1;
    endtask

    task automatic wait_sel(input bit want);
        int k;
        k = 0;
        while (sel === want && k < 12) begin cyc(); k++; end
        k = 0;
        while (sel !== want && k < 12) begin cyc(); k++; end
        check("sel_reached", 8'(sel), 8'(want));
        cyc();
    endtask

    initial begin
        #1 nrst = 1'b0;
        model_reset();
        #1;
        check("por_grant", 8'(grant), 8'h00);
        check("por_sel", 8'(sel), 8'h00);
        check("por_seg", 8'(seg), 8'h00);
        cyc();
        cyc();

        // Single requester
        req = 2'b01; data0 = 8'h3C; data1 = 8'hA5;
        nrst = 1'b1;
        cyc();
        check("single_grant_latency", 8'(grant), 8'h01);
        wait_sel(1'b1);
        check("single_seg_upper", 8'(seg), 8'h79);
        wait_sel(1'b0);
        check("single_seg_lower", 8'(seg), 8'h4E);
        repeat (16) cyc();
        check("single_hold_keeps", 8'(grant), 8'h01);

        // Asynchronous reset in OWN
        @(posedge clk);
        model_step();
        #2 nrst = 1'b0;
        model_reset();
        #1;
        check("async_rst_grant", 8'(grant), 8'h00);
        check("async_rst_sel", 8'(sel), 8'h00);
        check("async_rst_seg", 8'(seg), 8'h00);
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) cyc();
        check("first_tick_not_early", 8'(sel), 8'h00);
        cyc();
        check("first_tick_at_4", 8'(sel), 8'h01);

        // Tie after reset: round robin with handoff gaps
        req = 2'b11; data0 = 8'h3C; data1 = 8'hA5;
        do_reset();
        for (int k = 1; k <= 33; k++) begin
            cyc();
            case (k)
                1:  check("tie_first_req0", 8'(grant), 8'h01);
                11: check("tie_hold_req0", 8'(grant), 8'h01);
                12: check("tie_handoff", 8'(grant), 8'h00);
                13: check("tie_handoff_blank", 8'(seg), 8'h00);
                15: check("tie_handoff_waits", 8'(grant), 8'h00);
                16: check("tie_req1_wins", 8'(grant), 8'h10 >> 3);
                17: check("tie_data1_shown", 8'(seg), 8'h5B);
                27: check("tie_hold_req1", 8'(grant), 8'h02);
                28: check("tie_handoff2", 8'(grant), 8'h00);
                32: check("tie_back_to_req0", 8'(grant), 8'h01);
                default: ;
            endcase
        end

        // Owner drops mid-hold
        req = 2'b11;
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            cyc();
            if (k == 1) check("drop_initial", 8'(grant), 8'h01);
            if (k == 5) req = 2'b10;
            if (k == 6) check("drop_next_clk", 8'(grant), 8'h00);
            if (k == 7) check("drop_waits_tick", 8'(grant), 8'h00);
            if (k == 8) check("drop_regrant", 8'(grant), 8'h02);
        end

        // Leading zero on the upper digit
        req = 2'b01; data0 = 8'h05;
        do_reset();
        wait_sel(1'b1);
`ifdef SSD_LEADING_ZERO_BLANK_EN
        check("lead_zero_upper", 8'(seg), 8'h00);
`else
        check("lead_zero_upper", 8'(seg), 8'h7E);
`endif
        wait_sel(1'b0);
        check("lead_zero_lower", 8'(seg), 8'h5B);

        // Release all requests: fall back to idle
        req = 2'b00;
        repeat (12) cyc();
        check("idle_grant", 8'(grant), 8'h00);
        check("idle_seg", 8'(seg), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
